// File: rtl/ps2_host_tx_if.sv
// Host-side request/status bundle for the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic       i_start;
  logic [7:0] i_byte;
  logic       o_busy;
  logic       o_done;
  logic       o_err;

  modport master (output i_start, output i_byte, input o_busy, input o_done, input o_err);
  modport slave  (input i_start, input i_byte, output o_busy, output o_done, output o_err);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter: inhibit, request-to-send, clocked
// frame output on device falling edges, ack sampling and timeout recovery.
module ps2_host_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQ_CYCLES     = 50,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk,
  input  logic          i_sclr_n,
  input  logic          i_ps2_clk,
  input  logic          i_ps2_dat,
  ps2_host_tx_if.slave  host,
  output logic          o_ps2_clk_oe,
  output logic          o_ps2_dat_oe
);

  localparam int unsigned MAX_AB     = (INHIBIT_CYCLES > REQ_CYCLES) ? INHIBIT_CYCLES : REQ_CYCLES;
  localparam int unsigned MAX_CYCLES = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam int unsigned IDX_W      = 4;
  localparam int unsigned FRAME_W    = 10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQ,
    S_SEND,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [FRAME_W-1:0]   frame, frame_nxt;
  logic                 clk_oe_nxt, dat_oe_nxt;
  logic                 busy_nxt, done_nxt, err_nxt;

  logic clk_s1, clk_s2, clk_d;
  logic dat_s1, dat_s2;
  logic fall_c;
  logic timeout_c;

  // Line synchronizers; reset to the idle (released-high) level
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_d  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= i_ps2_clk;
      clk_s2 <= clk_s1;
      clk_d  <= clk_s2;
      dat_s1 <= i_ps2_dat;
      dat_s2 <= dat_s1;
    end
  end

  assign fall_c    = clk_d & ~clk_s2;
  assign timeout_c = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!i_sclr_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      bit_idx      <= '0;
      frame        <= '0;
      o_ps2_clk_oe <= 1'b0;
      o_ps2_dat_oe <= 1'b0;
      host.o_busy  <= 1'b0;
      host.o_done  <= 1'b0;
      host.o_err   <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      bit_idx      <= bit_idx_nxt;
      frame        <= frame_nxt;
      o_ps2_clk_oe <= clk_oe_nxt;
      o_ps2_dat_oe <= dat_oe_nxt;
      host.o_busy  <= busy_nxt;
      host.o_done  <= done_nxt;
      host.o_err   <= err_nxt;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    bit_idx_nxt = bit_idx;
    frame_nxt   = frame;
    clk_oe_nxt  = o_ps2_clk_oe;
    dat_oe_nxt  = o_ps2_dat_oe;
    done_nxt    = 1'b0;
    err_nxt     = host.o_err;

    case (state)
      S_IDLE: begin
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
        if (host.i_start) begin
          frame_nxt  = {1'b1, ~^host.i_byte, host.i_byte};
          err_nxt    = 1'b0;
          cnt_nxt    = '0;
          clk_oe_nxt = 1'b1;
          state_nxt  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt == CNT_W'(INHIBIT_CYCLES - 1)) begin
          cnt_nxt    = '0;
          dat_oe_nxt = 1'b1;
          state_nxt  = S_REQ;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_REQ: begin
        if (cnt == CNT_W'(REQ_CYCLES - 1)) begin
          cnt_nxt     = '0;
          clk_oe_nxt  = 1'b0;
          bit_idx_nxt = '0;
          state_nxt   = S_SEND;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_SEND: begin
        cnt_nxt = cnt + CNT_W'(1);
        if (fall_c) begin
          dat_oe_nxt  = ~frame[bit_idx];
          bit_idx_nxt = bit_idx + IDX_W'(1);
          if (bit_idx == IDX_W'(FRAME_W - 1)) begin
            state_nxt = S_ACK;
          end
        end
        // Abort wins over any bit shifted out on the expiring cycle
        if (timeout_c) begin
          err_nxt    = 1'b1;
          clk_oe_nxt = 1'b0;
          dat_oe_nxt = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = S_WAIT_IDLE;
        end
      end

      S_ACK: begin
        cnt_nxt    = cnt + CNT_W'(1);
        dat_oe_nxt = 1'b0;
        if (fall_c) begin
          err_nxt   = dat_s2;
          state_nxt = S_WAIT_IDLE;
        end else if (timeout_c) begin
          err_nxt    = 1'b1;
          clk_oe_nxt = 1'b0;
          done_nxt   = 1'b1;
          state_nxt  = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        // o_done is issued while still busy so a coincident i_start is dropped
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
        if (host.o_done) begin
          state_nxt = S_IDLE;
        end else if (clk_s2 && dat_s2) begin
          done_nxt = 1'b1;
        end
      end

      default: begin
        state_nxt  = S_IDLE;
        clk_oe_nxt = 1'b0;
        dat_oe_nxt = 1'b0;
      end
    endcase

    busy_nxt = (state_nxt != S_IDLE);
  end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 SHALL have parameter INHIBIT_CYCLES, default 5000, clock-low inhibit time in clk cycles (100 us at 50 MHz).
REQ-002 SHALL have parameter REQ_CYCLES, default 50, cycles data is held low before clock release.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 1000000, max cycles from clock release to ack (20 ms at 50 MHz).
REQ-004 SHALL have port clk, input, 1, single system clock; all logic on its rising edge.
REQ-005 SHALL have port i_sclr_n, input, 1, synchronous active-low reset.
REQ-006 SHALL have port i_ps2_clk, input, 1, raw PS/2 clock line level (asynchronous).
REQ-007 SHALL have port i_ps2_dat, input, 1, raw PS/2 data line level (asynchronous).
REQ-008 SHALL have port i_start, input, 1, request to send i_byte; honoured only while idle.
REQ-009 SHALL have port i_byte, input, 8, command byte; captured on an accepted i_start.
REQ-010 SHALL have port o_ps2_clk_oe, output, 1, 1 = drive PS/2 clock low (open drain), 0 = release.
REQ-011 SHALL have port o_ps2_dat_oe, output, 1, 1 = drive PS/2 data low (open drain), 0 = release.
REQ-012 SHALL have port o_busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port o_done, output, 1, one-cycle pulse at end of each transfer.
REQ-014 SHALL have port o_err, output, 1, status of the last transfer, valid from o_done until next accepted i_start; 1 = no ack or timeout.

Function
REQ-015 SHALL pass i_ps2_clk and i_ps2_dat through 2-FF synchronizers; a falling edge = synced clock 1 then 0 on consecutive cycles.
REQ-016 SHALL implement states IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE.
REQ-017 IDLE: both oe = 0; i_start=1 -> latch i_byte, compute odd parity (parity bit = ~^byte), clear o_err, go INHIBIT next cycle.
REQ-018 INHIBIT: o_ps2_clk_oe=1, o_ps2_dat_oe=0 for exactly INHIBIT_CYCLES cycles, then go REQ.
REQ-019 REQ: o_ps2_clk_oe=1, o_ps2_dat_oe=1 (start bit) for exactly REQ_CYCLES cycles, then release clock and go SEND with bit index 0.
REQ-020 SEND: on each device falling edge drive the next frame bit. Order: data bits 0..7 LSB first, then parity, then stop. Bit value 0 -> dat_oe=1; bit value 1 -> dat_oe=0.
REQ-021 SEND: the stop bit is applied on the 10th falling edge with dat_oe=0. The state then goes ACK.
REQ-022 ACK: on the 11th falling edge sample synced data; 0 = ack ok, 1 = set o_err; go WAIT_IDLE; dat_oe stays 0.
REQ-023 WAIT_IDLE: wait until synced clock and data are both 1, then pulse o_done for one cycle and return to IDLE.
REQ-024 SHALL run a timeout counter from entry to SEND. If TIMEOUT_CYCLES elapse before the ACK sample, it SHALL set o_err=1, release both lines, pulse o_done and go IDLE.
REQ-025 i_start while o_busy=1 SHALL be ignored with no effect on the frame in flight.
REQ-026 i_byte changes after acceptance SHALL NOT affect the frame in flight.
REQ-027 Falling edges seen in IDLE, INHIBIT or REQ SHALL be ignored.
REQ-028 o_done and i_start in the same cycle: o_done completes; i_start is ignored because state is not yet IDLE.
REQ-029 o_ps2_clk_oe and o_ps2_dat_oe SHALL be registered outputs (glitch-free).

Reset
REQ-030 i_sclr_n=0 at any clock edge SHALL force IDLE and set o_ps2_clk_oe=0, o_ps2_dat_oe=0, o_busy=0, o_done=0, o_err=0.
REQ-031 Reset SHALL also clear all counters, the bit index, the latched byte and the synchronizers (synchronizer reset value 1 = idle line).
REQ-032 Reset asserted mid-transfer SHALL release both lines on the next cycle with no o_done pulse.

Verification (INHIBIT_CYCLES=8, REQ_CYCLES=4, TIMEOUT_CYCLES=2000; device model clocks at 40 cycles/bit)
REQ-033 Send 0xED with device ack -> data bits 1,0,1,1,0,1,1,1 then parity 1 then stop 1; o_done pulses once, o_err=0.
REQ-034 Send 0xF4, device leaves data high at edge 11 -> parity 0 sent; o_done pulses, o_err=1.
REQ-035 Accept i_start, device never clocks -> o_ps2_clk_oe high 8 cycles, both oe high 4 cycles, then after 2000 cycles o_done=1, o_err=1, lines released.
REQ-036 Pulse i_start mid-SEND with a different i_byte -> the transmitted frame is unchanged and only one o_done pulse occurs.
REQ-037 Assert i_sclr_n=0 at bit 5 of 0x00 -> next cycle both oe=0 and o_busy=0, no o_done; a following send of 0x00 completes with parity 1.
REQ-038 Device falling edges injected during INHIBIT -> the frame still starts with bit0 on the first edge after clock release.
